dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/trace_fifo.sv | 53 +++++
 rtl/dmem_responder.sv | 116 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its write-trace FIFO.
// A trace entry is {word-aligned address, write data, byte enables}.
package dmem_pkg;

  localparam int TRACE_W    = 68;
  localparam int DROP_CNT_W = 16;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } trace_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with valid/ready pop; a push into a full FIFO is accepted
// only when the head is popped on the same edge. The head is read combinationally.
module trace_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = TRACE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_ready,
  output logic             o_empty,
  output logic             o_full,
  output logic [WIDTH-1:0] o_head
);

  localparam int PW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_pop   = !o_empty && i_ready;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_head  = r_mem[r_rd_ptr[PW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // slots are valid, and resetting an array costs a mux per bit.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for a CPU test harness: word RAM with byte-lane writes,
// a tohost status register, and a FIFO trace of every accepted write.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          MEM_SIZE_WORDS = 1024,
  parameter int          TRACE_DEPTH    = 8,
  parameter logic [31:0] TOHOST_ADDR    = TOHOST_ADDR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           d_mem_addr,
  input  logic [31:0]           d_mem_wdata,
  input  logic [3:0]            d_mem_wen,
  output logic [31:0]           d_mem_rdata,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic [31:0]           trace_addr,
  output logic [31:0]           trace_data,
  output logic [3:0]            trace_be,
  output logic [DROP_CNT_W-1:0] trace_drop_cnt,
  output logic                  test_done,
  output logic [31:0]           test_code
);

  localparam int          AW        = (MEM_SIZE_WORDS > 1) ? $clog2(MEM_SIZE_WORDS) : 1;
  localparam logic [29:0] MEM_WORDS = 30'(MEM_SIZE_WORDS);

  logic [31:0]           r_mem [MEM_SIZE_WORDS];
  logic                  r_test_done;
  logic [31:0]           r_test_code;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic [29:0]  w_word_addr;
  logic [AW-1:0] w_idx;
  logic         w_in_ram;
  logic         w_is_tohost;
  logic         w_push;
  logic         w_pop;
  logic         w_drop;
  logic         w_fifo_empty;
  logic         w_fifo_full;
  trace_entry_t w_push_entry;
  trace_entry_t w_head_entry;

  assign w_word_addr = d_mem_addr[31:2];
  assign w_idx       = w_word_addr[AW-1:0];
  assign w_in_ram    = (w_word_addr < MEM_WORDS);
  assign w_is_tohost = (w_word_addr == TOHOST_ADDR[31:2]);

  // RAM wins if the tohost word is ever configured inside the RAM window.
  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    d_mem_rdata = 32'h0;
    if (w_in_ram)         d_mem_rdata = r_mem[w_idx];
    else if (w_is_tohost) d_mem_rdata = r_test_code;
  end

  // rst_n gates the write so nothing lands in RAM while the core is held in reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_in_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (d_mem_wen[b]) r_mem[w_idx][8*b +: 8] <= d_mem_wdata[8*b +: 8];
      end
    end
  end

  // Only full-word writes before completion update the status register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_test_done <= 1'b0;
      r_test_code <= 32'h0;
    end else if (w_is_tohost && !w_in_ram && (d_mem_wen == 4'b1111) && !r_test_done) begin
      r_test_code <= d_mem_wdata;
      r_test_done <= d_mem_wdata[0];
    end
  end

  assign w_push = (d_mem_wen != 4'b0000) && (w_in_ram || w_is_tohost);
  assign w_pop  = trace_valid && trace_ready;
  assign w_drop = w_push && w_fifo_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end
  end

  assign w_push_entry = '{addr: word_align(d_mem_addr), data: d_mem_wdata, be: d_mem_wen};

  trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (TRACE_W)
  ) u_trace_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_ready     (trace_ready),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full),
    .o_head      (w_head_entry)
  );

  assign trace_valid    = !w_fifo_empty;
  assign trace_addr     = w_head_entry.addr;
  assign trace_data     = w_head_entry.data;
  assign trace_be       = w_head_entry.be;
  assign trace_drop_cnt = r_drop_cnt;
  assign test_done      = r_test_done;
  assign test_code      = r_test_code;

endmodule
